// File: rtl/rl_ctrl_pkg.sv
// rtl/rl_ctrl_pkg.sv - shared state encoding and max helper for the iteration controller
package rl_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_NUM,
        BCAST,
        DRAIN,
        MU_START,
        MU_WAIT
    } state_t;

    localparam int MAX_FIELD_W = 32;

    // One step of the max-reduce over per-cell particle counts.
    function automatic logic [MAX_FIELD_W-1:0] max_of(
        input logic [MAX_FIELD_W-1:0] a,
        input logic [MAX_FIELD_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rl_delay_line.sv
// rtl/rl_delay_line.sv - reset-to-zero register pipe; DEPTH of 0 degenerates to a wire
module rl_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] aligned
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign aligned = raw;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= raw;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign aligned = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/rl_iteration_controller.sv
// rtl/rl_iteration_controller.sv - sequences MD iterations: count read, broadcast, drain, motion update
module rl_iteration_controller
    import rl_ctrl_pkg::*;
#(
    parameter int NUM_CELLS         = 64,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NUM_PHASES        = 2,
    parameter int PHASE_WIDTH       = 1,
    parameter int RD_LATENCY        = 2,
    parameter int ALIGN_DELAY       = 2,
    parameter int DRAIN_CYCLES      = 8,
    parameter int ITER_WIDTH        = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [ITER_WIDTH-1:0]                  num_iterations,
    input  logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] particle_num,
    input  logic [NUM_CELLS-1:0]                   back_pressure,
    input  logic [NUM_CELLS-1:0]                   filter_buffer_empty,
    input  logic [NUM_CELLS-1:0]                   reading_done,
    input  logic                                   force_path_empty,
    input  logic                                   mu_done,
    output logic [PARTICLE_ID_WIDTH-1:0]           rd_addr,
    output logic [PARTICLE_ID_WIDTH-1:0]           particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0]           ref_id,
    output logic [PHASE_WIDTH-1:0]                 phase,
    output logic                                   reading_particle_num,
    output logic                                   pause_reading,
    output logic                                   motion_update_start,
    output logic [ITER_WIDTH-1:0]                  iter_count,
    output logic                                   busy,
    output logic                                   run_done
);

    localparam int RD_CNT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam int QUIET_W  = $clog2(DRAIN_CYCLES + 1);
    localparam int BUS_W    = 3 * PARTICLE_ID_WIDTH + PHASE_WIDTH + 2;

    typedef logic [PARTICLE_ID_WIDTH-1:0] pid_t;

    state_t                  state, state_next;
    logic [RD_CNT_W-1:0]     rd_cnt;
    pid_t                    id_cnt, ref_cnt, max_num, max_calc;
    logic [PHASE_WIDTH-1:0]  ph_cnt;
    logic [QUIET_W-1:0]      quiet_cnt;
    logic [ITER_WIDTH-1:0]   iter_target, iter_next;
    logic                    pause, rnum, quiet;
    logic                    read_last, id_last, ref_last, ph_last, drain_done, run_end;

    always_comb begin
        max_calc = '0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            max_calc = pid_t'(max_of(
                MAX_FIELD_W'(particle_num[c*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH]),
                MAX_FIELD_W'(max_calc)));
        end
    end

    assign quiet      = (&reading_done) & (&filter_buffer_empty) & force_path_empty;
    assign read_last  = (rd_cnt == RD_CNT_W'(RD_LATENCY));
    assign id_last    = (id_cnt == max_num - pid_t'(1));
    assign ref_last   = (ref_cnt == max_num - pid_t'(1));
    assign ph_last    = (ph_cnt == PHASE_WIDTH'(NUM_PHASES - 1));
    assign drain_done = quiet && (quiet_cnt == QUIET_W'(DRAIN_CYCLES - 1));
    assign iter_next  = iter_count + ITER_WIDTH'(1);
    assign run_end    = (iter_target != '0) && (iter_next == iter_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pause      = 1'b0;
        rnum       = 1'b0;
        case (state)
            IDLE:     if (start) state_next = READ_NUM;
            READ_NUM: begin
                rnum = 1'b1;
                if (read_last) state_next = (max_calc == '0) ? DRAIN : BCAST;
            end
            BCAST: begin
                pause = |back_pressure;
                if (!pause && id_last && ref_last && ph_last) state_next = DRAIN;
            end
            DRAIN:    if (drain_done) state_next = MU_START;
            MU_START: state_next = MU_WAIT;
            MU_WAIT:  if (mu_done) state_next = run_end ? IDLE : READ_NUM;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt      <= '0;
            id_cnt      <= '0;
            ref_cnt     <= '0;
            ph_cnt      <= '0;
            max_num     <= '0;
            quiet_cnt   <= '0;
            iter_count  <= '0;
            iter_target <= '0;
            run_done    <= 1'b0;
        end else begin
            run_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_target <= num_iterations;
                        iter_count  <= '0;
                    end
                end
                READ_NUM: begin
                    rd_cnt  <= read_last ? '0 : rd_cnt + RD_CNT_W'(1);
                    id_cnt  <= '0;
                    ref_cnt <= '0;
                    ph_cnt  <= '0;
                    if (read_last) max_num <= max_calc;
                end
                BCAST: begin
                    // Nested wrap: ID is innermost, then REF, then phase.
                    if (!pause) begin
                        if (id_last) begin
                            id_cnt <= '0;
                            if (ref_last) begin
                                ref_cnt <= '0;
                                ph_cnt  <= ph_last ? '0 : ph_cnt + PHASE_WIDTH'(1);
                            end else begin
                                ref_cnt <= ref_cnt + pid_t'(1);
                            end
                        end else begin
                            id_cnt <= id_cnt + pid_t'(1);
                        end
                    end
                end
                DRAIN: quiet_cnt <= (quiet && !drain_done) ? quiet_cnt + QUIET_W'(1) : '0;
                MU_WAIT: begin
                    if (mu_done) begin
                        iter_count <= iter_next;
                        run_done   <= run_end;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_addr             = id_cnt;
    assign motion_update_start = (state == MU_START);
    assign busy                = (state != IDLE);

    rl_delay_line #(
        .WIDTH(BUS_W),
        .DEPTH(ALIGN_DELAY)
    ) u_align (
        .clk    (clk),
        .rst    (rst),
        .raw    ({id_cnt, ref_cnt, ph_cnt, rnum, pause}),
        .aligned({particle_id, ref_id, phase, reading_particle_num, pause_reading})
    );

endmodule

// File: tb/tb_rl_iteration_controller.sv
// tb/tb_rl_iteration_controller.sv - directed table and sequence bench for rl_iteration_controller
module tb_rl_iteration_controller;
    import rl_ctrl_pkg::*;

    localparam int NC = 64;
    localparam int PW = 7;
    localparam int IW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [IW-1:0]   num_iterations = '0;
    logic [NC*PW-1:0] particle_num = '0;
    logic [NC-1:0]   back_pressure = '0;
    logic [NC-1:0]   filter_buffer_empty = '1;
    logic [NC-1:0]   reading_done = '1;
    logic            force_path_empty = 1'b1;
    logic            mu_done = 1'b0;
    logic [PW-1:0]   rd_addr, particle_id, ref_id;
    logic [0:0]      phase;
    logic            reading_particle_num, pause_reading, motion_update_start, busy, run_done;
    logic [IW-1:0]   iter_count;

    rl_iteration_controller dut (
        .clk(clk), .rst(rst), .start(start), .num_iterations(num_iterations),
        .particle_num(particle_num), .back_pressure(back_pressure),
        .filter_buffer_empty(filter_buffer_empty), .reading_done(reading_done),
        .force_path_empty(force_path_empty), .mu_done(mu_done),
        .rd_addr(rd_addr), .particle_id(particle_id), .ref_id(ref_id), .phase(phase),
        .reading_particle_num(reading_particle_num), .pause_reading(pause_reading),
        .motion_update_start(motion_update_start), .iter_count(iter_count),
        .busy(busy), .run_done(run_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int bcast_cnt, mu_cnt, done_cnt, rnum_cnt, mu_wait, n;
    logic in_bcast;

    typedef struct {
        int fill; int c0; int c1; int iters; int bp_at; int bp_len;
        int exp_bcast; int exp_mu; int exp_done; int exp_rnum; int exp_iter; int exp_busy;
    } vec_t;
    vec_t vecs[5];
    vec_t v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        in_bcast = (dut.state == BCAST);
        if (in_bcast) bcast_cnt++;
        if (motion_update_start) begin mu_cnt++; mu_wait = 3; end
        if (run_done) done_cnt++;
        if (reading_particle_num) rnum_cnt++;
        mu_done = 1'b0;
        if (mu_wait > 0) begin
            mu_wait--;
            if (mu_wait == 0) mu_done = 1'b1;
        end
    endtask

    task automatic clear_stats();
        bcast_cnt = 0; mu_cnt = 0; done_cnt = 0; rnum_cnt = 0; mu_wait = 0;
    endtask

    task automatic set_counts(input int fill, input int c0, input int c1);
        for (int c = 0; c < NC; c++) particle_num[c*PW +: PW] = PW'(fill);
        particle_num[0 +: PW]  = PW'(c0);
        particle_num[PW +: PW] = PW'(c1);
    endtask

    task automatic begin_run(input int iters);
        num_iterations = IW'(iters);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_run(input int limit);
        int k;
        k = 0;
        while (done_cnt == 0 && k < limit) begin step(); k++; end
        check("run_done_seen", 64'(done_cnt), 64'd1);
    endtask

    task automatic trace_run(input bit bp_on);
        int u;
        int uh[32];
        bit ph_h[32];
        bit paused;
        int k;
        clear_stats();
        set_counts(3, 3, 3);
        begin_run(1);
        k = 0;
        while (dut.state != BCAST && k < 20) begin step(); k++; end
        check("bcast_entry", 64'(dut.state == BCAST), 64'd1);
        u = 0;
        for (int j = 0; j < 24; j++) begin
            if (j > 0) step();
            if (u < 18) check($sformatf("rd_addr[%0d]", j), 64'(rd_addr), 64'(u % 3));
            uh[j] = u;
            paused = bp_on && (j >= 5) && (j < 9);
            ph_h[j] = paused;
            if (j >= 2 && uh[j-2] < 18) begin
                check($sformatf("particle_id[%0d]", j), 64'(particle_id), 64'(uh[j-2] % 3));
                check($sformatf("ref_id[%0d]", j), 64'(ref_id), 64'((uh[j-2] / 3) % 3));
                check($sformatf("phase[%0d]", j), 64'(phase), 64'(uh[j-2] / 9));
                check($sformatf("pause_reading[%0d]", j), 64'(pause_reading), 64'(ph_h[j-2]));
            end
            back_pressure = '0;
            back_pressure[5] = paused;
            if (!paused) u++;
        end
        back_pressure = '0;
        finish_run(500);
    endtask

    task automatic drain_run(input int drop_at, input int exp_at);
        int k;
        clear_stats();
        set_counts(0, 0, 0);
        begin_run(1);
        k = 0;
        while (dut.state != DRAIN && k < 20) begin step(); k++; end
        check("drain_entry", 64'(dut.state == DRAIN), 64'd1);
        check("drain_no_bcast", 64'(bcast_cnt), 64'd0);
        for (int d = 0; d <= exp_at; d++) begin
            if (d > 0) step();
            check($sformatf("mu_start_drain%0d[%0d]", drop_at, d),
                  64'(motion_update_start), 64'(d == exp_at));
            force_path_empty = (d != drop_at);
        end
        force_path_empty = 1'b1;
        finish_run(100);
    endtask

    initial begin
        vecs[0] = '{3, 3, 3, 1, 0, 0,  18, 1, 1,  3, 1, 0};
        vecs[1] = '{3, 3, 3, 1, 7, 4,  22, 1, 1,  3, 1, 0};
        vecs[2] = '{0, 0, 0, 1, 0, 0,   0, 1, 1,  3, 1, 0};
        vecs[3] = '{0, 7, 2, 3, 0, 0, 294, 3, 1,  9, 3, 0};
        vecs[4] = '{0, 1, 0, 0, 0, 0,  10, 5, 0, 15, 5, 1};
        clear_stats();

        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({rd_addr, particle_id, ref_id, phase, reading_particle_num,
              pause_reading, motion_update_start, iter_count, busy, run_done}), 64'd0);
        rst = 1'b0;
        step();
        check("idle_not_busy", 64'(busy), 64'd0);

        trace_run(1'b0);
        check("trace_iter_count", 64'(iter_count), 64'd1);
        check("trace_mu_pulses", 64'(mu_cnt), 64'd1);
        trace_run(1'b1);

        drain_run(-1, 8);
        drain_run(5, 14);

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            clear_stats();
            set_counts(v.fill, v.c0, v.c1);
            begin_run(v.iters);
            n = 0;
            while (done_cnt == 0 && !(v.iters == 0 && iter_count == IW'(5)) && n < 3000) begin
                step();
                n++;
                back_pressure = '0;
                if (in_bcast && v.bp_len > 0 && bcast_cnt > v.bp_at && bcast_cnt <= v.bp_at + v.bp_len)
                    back_pressure[5] = 1'b1;
            end
            back_pressure = '0;
            check($sformatf("vec%0d_bcast_cycles", i), 64'(bcast_cnt), 64'(v.exp_bcast));
            check($sformatf("vec%0d_mu_pulses", i), 64'(mu_cnt), 64'(v.exp_mu));
            check($sformatf("vec%0d_run_done", i), 64'(done_cnt), 64'(v.exp_done));
            check($sformatf("vec%0d_rnum", i), 64'(rnum_cnt), 64'(v.exp_rnum));
            check($sformatf("vec%0d_iter_count", i), 64'(iter_count), 64'(v.exp_iter));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(v.exp_busy));
            if (v.exp_busy != 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        // Stray start/mu_done mid-broadcast, then asynchronous abort.
        clear_stats();
        set_counts(0, 7, 2);
        begin_run(2);
        n = 0;
        while (dut.state != BCAST && n < 20) begin step(); n++; end
        check("abort_bcast_entry", 64'(dut.state == BCAST), 64'd1);
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j >= 11) check($sformatf("stray_rd_addr[%0d]", j), 64'(rd_addr), 64'(j % 7));
            start   = (j == 10);
            mu_done = (j == 10);
        end
        start = 1'b0;
        mu_done = 1'b0;
        check("stray_iter_count", 64'(iter_count), 64'd0);
        check("stray_busy", 64'(busy), 64'd1);
        check("stray_state", 64'(dut.state == BCAST), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'({rd_addr, particle_id, ref_id, phase, reading_particle_num,
              pause_reading, motion_update_start, iter_count, busy, run_done}), 64'd0);
        check("async_reset_state", 64'(dut.state == IDLE), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        for (int j = 0; j < 6; j++) step();
        check("post_abort_no_pulses", 64'(mu_cnt + done_cnt), 64'd0);
        check("post_abort_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rl_iteration_controller.md
Name: rl_iteration_controller

Overview:
- Parametrised successor to the range-limited broadcast sequencer.
- Sequences one or more full MD iterations: particle-count read, multi-phase neighbour broadcast with back-pressure pause, network drain, motion-update handshake.
- Replaces the fixed 2-stage delay registers around PE inputs with a parametrised alignment pipe, and adds a drain guard for in-flight force packets.
- Sits between the position caches, the PE array and motion_update_control.

Parameters:
- NUM_CELLS, 64, number of home cells/PEs
- PARTICLE_ID_WIDTH, 7, particle index width
- NUM_PHASES, 2, broadcast phases per iteration (>=1)
- PHASE_WIDTH, 1, clog2(NUM_PHASES), minimum 1
- RD_LATENCY, 2, cache read latency in cycles
- ALIGN_DELAY, 2, register stages on PE-side control outputs (>=0)
- DRAIN_CYCLES, 8, consecutive quiet cycles required before motion update
- ITER_WIDTH, 16, iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin run; ignored unless IDLE
- num_iterations  in  ITER_WIDTH  iterations per run, sampled on start; 0 = run until reset
- particle_num  in  NUM_CELLS*PARTICLE_ID_WIDTH  per-cell particle counts
- back_pressure  in  NUM_CELLS  per-PE stall request
- filter_buffer_empty  in  NUM_CELLS  per-PE filter buffers empty
- reading_done  in  NUM_CELLS  per-PE reading complete
- force_path_empty  in  1  writeback network and force-cache input buffers empty
- mu_done  in  1  motion update finished (1-cycle pulse)
- rd_addr  out  PARTICLE_ID_WIDTH  undelayed particle_id to position caches
- particle_id  out  PARTICLE_ID_WIDTH  delayed neighbour id to PEs
- ref_id  out  PARTICLE_ID_WIDTH  delayed reference id
- phase  out  PHASE_WIDTH  delayed phase
- reading_particle_num  out  1  delayed count-read strobe
- pause_reading  out  1  delayed pause
- motion_update_start  out  1  one-cycle pulse
- iter_count  out  ITER_WIDTH  completed iterations
- busy  out  1  not IDLE
- run_done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: state=IDLE. All outputs, counters and alignment stages are 0. Reset mid-operation aborts immediately, with no pulse.
- The raw control signals are ID, REF, PH, RNUM and PAUSE. particle_id, ref_id, phase, reading_particle_num and pause_reading are these signals passed through ALIGN_DELAY stages. rd_addr = raw ID with no delay.
- IDLE:
  - On start, latch num_iterations, clear iter_count and go to READ_NUM.
- READ_NUM:
  - RNUM=1 for RD_LATENCY+1 cycles.
  - On the last cycle, latch max_num = maximum of the NUM_CELLS particle_num fields.
  - If max_num==0, go to DRAIN. Otherwise clear ID, REF and PH, then go to BCAST.
- BCAST: PAUSE = OR of back_pressure, combinational from inputs.
  - When PAUSE=1, counters hold.
  - When PAUSE=0, ID increments.
  - If ID==max_num-1: ID wraps to 0 and REF increments.
  - If REF==max_num-1 as well: REF wraps to 0 and PH increments.
  - If PH==NUM_PHASES-1 as well: go to DRAIN with ID, REF and PH cleared.
  - Each phase therefore issues exactly max_num² unpaused cycles.
- DRAIN:
  - quiet = AND of reading_done & AND of filter_buffer_empty & force_path_empty.
  - A quiet counter increments while quiet and resets to 0 on any non-quiet cycle.
  - When the counter reaches DRAIN_CYCLES, go to MU_START.
- MU_START:
  - motion_update_start=1 for one cycle, then go to MU_WAIT.
- MU_WAIT:
  - On mu_done, iter_count increments.
  - If num_iterations!=0 and the new iter_count==num_iterations: run_done pulses and the next state is IDLE.
  - Otherwise go to READ_NUM.
- mu_done outside MU_WAIT is ignored. start while busy is ignored.
- iter_count wraps modulo 2^ITER_WIDTH in free-run mode.
- busy=1 in every state except IDLE. It is registered and goes high the cycle after start is accepted.

Decomposition:
- Package rl_ctrl_pkg holds the state enum (IDLE, READ_NUM, BCAST, DRAIN, MU_START, MU_WAIT) and the max-reduce function.
- Sub-module rl_delay_line(WIDTH, DEPTH): a generic reset-to-zero register pipe. DEPTH=0 is a wire. One instance is used for the concatenated PE-side control bus.

Test Plan:
- All particle_num=3, NUM_PHASES=2, no back_pressure, num_iterations=1, quiet inputs:
  - BCAST lasts 18 cycles.
  - rd_addr sequence 0,1,2,0,1,2…, with ref stepping every 3 cycles.
  - particle_id lags rd_addr by exactly 2 cycles.
  - One motion_update_start; run_done after mu_done; iter_count=1.
- Back-pressure: back_pressure[5]=1 for 4 cycles mid-BCAST:
  - rd_addr, REF and PH frozen for those 4 cycles.
  - pause_reading asserted 2 cycles later.
  - Total BCAST length 18+4 cycles.
- Drain guard: force_path_empty drops for 1 cycle after 5 quiet cycles:
  - motion_update_start only after 8 further consecutive quiet cycles.
- Empty cells: all particle_num=0:
  - No BCAST cycles; goes straight to DRAIN.
  - motion_update_start asserted DRAIN_CYCLES after quiet begins.
- Multi-iteration and counts:
  - num_iterations=3 with counts {7,2,0,…}: max_num=7, 98 BCAST cycles per iteration, 3 motion_update_start pulses, one run_done, iter_count=3.
  - num_iterations=0: still busy after 5 iterations.
- Reset and stray inputs:
  - rst asserted mid-BCAST: all outputs 0 asynchronously, state IDLE.
  - Spurious start and mu_done while in BCAST have no effect.
